melody_beat_seq: RTL
====================

# melody_beat_seq

Beat sequencer that sits directly upstream of the note-lookup ROM in the audio path. It divides the system clock into beats and runs a play/pause/loop state machine driven by a raw push-button. It emits the current beat index that the ROM maps to a tone frequency, plus a mute flag that the tone generator uses to silence output. It replaces the free-running beat PWM as the timing source for playback.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `BEAT_HZ`, 8, beats per second; `BEAT_DIV = CLK_HZ/BEAT_HZ` cycles per beat (integer, ≥ 2).
- `LAST_BEAT`, 8'd127, index of the final beat of the melody.
- `GAP_CYC`, 1_000_000, silent cycles at the end of each beat (gap build only); must be < `BEAT_DIV`.

Ports:
- `clk` in 1 — system clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `play` in 1 — raw button level, asynchronous to `clk`; each rising edge toggles play/pause.
- `loop` in 1 — level; sampled only at the end of `LAST_BEAT`.
- `beatnum` out 8 — current beat index to the note ROM.
- `beat_tick` out 1 — one-cycle pulse when `beatnum` advances or wraps.
- `playing` out 1 — high in PLAY.
- `mute` out 1 — high when the tone generator must be silent.
- `done` out 1 — one-cycle pulse when a non-looped melody finishes.

## Operation
- Input conditioning: `play` → 2-flop synchronizer (`s1`, `s2`) → delay flop `d`; `play_edge = s2 & ~d`.
- Beat counter `cnt`, width `$clog2(BEAT_DIV)`:
  - PLAY: increments every cycle; at `cnt == BEAT_DIV-1` it returns to 0 and `beat_tick` is asserted.
  - PAUSE: holds its value.
  - IDLE: held at 0.
- States:
  - IDLE --play_edge--> PLAY; `beatnum` = 0, `cnt` = 0.
  - PLAY --play_edge--> PAUSE; `beatnum` and `cnt` frozen.
  - PAUSE --play_edge--> PLAY; resumes from the frozen `cnt` with no beat restart.
  - PLAY, tick with `beatnum < LAST_BEAT` → `beatnum + 1`.
  - PLAY, tick with `beatnum == LAST_BEAT` and `loop` = 1 → `beatnum` = 0, stays in PLAY.
  - PLAY, tick with `beatnum == LAST_BEAT` and `loop` = 0 → `beatnum` = 0, IDLE, `done` pulses.
- `beatnum` arithmetic is 8-bit unsigned and never exceeds `LAST_BEAT`; `LAST_BEAT` = 255 wraps to 0 only through the rules above.
- Simultaneous `play_edge` and tick in PLAY:
  - The tick is processed first: `beatnum` advances and `beat_tick` pulses.
  - The state then goes to PAUSE with `cnt` = 0.
  - If this tick is on `LAST_BEAT` with `loop` = 0, the next state is IDLE and `done` pulses; the edge is consumed.
- `loop` changes mid-melody have effect only at the `LAST_BEAT` tick.
- `mute` = `~playing`.

## Timing
- Reset (asynchronous, `rst` low): state IDLE, `cnt` = 0, `beatnum` = 0, `beat_tick` = 0, `playing` = 0, `done` = 0, `mute` = 1, synchronizer flops = 0.
- Reset release takes effect on the next rising edge; reset mid-melody discards all position.
- Play latency: taking the first rising edge that samples `play` high as edge 1, the state changes on edge 3.
  - `playing` and `mute` reflect the new state after edge 3.
- Outputs `beatnum`, `beat_tick`, `done` and `playing` are registered.
- `mute` is combinational from registered state and `cnt`.
- Beat length is exactly `BEAT_DIV` PLAY cycles, excluding paused cycles.
- `beat_tick` is high in the cycle after `cnt` was `BEAT_DIV-1`, coincident with the new `beatnum`.
- `done` is coincident with entering IDLE.
- A button held high produces exactly one edge; bounce is the board debouncer's responsibility.

## Configuration
- `MELODY_SEQ_GAP_EN` defined:
  - `mute = ~playing | (cnt >= BEAT_DIV-GAP_CYC)`.
  - This gives audible articulation between repeated notes; PAUSE keeps its own value of `mute` = 1.
- Not defined: `mute = ~playing`; `GAP_CYC` is unused.

## Test plan
Default bench parameters: `CLK_HZ` = 80, `BEAT_HZ` = 8 (`BEAT_DIV` = 10), `LAST_BEAT` = 3, `GAP_CYC` = 2.

1. Reset then `play` pulse, `loop` = 0 → `playing` rises on edge 3; `beatnum` goes 0,1,2,3 at 10-cycle spacing with a `beat_tick` at each; after beat 3, `beatnum` = 0, IDLE, one `done` pulse; 40 PLAY cycles in total.
2. `loop` = 1 → after beat 3, `beatnum` = 0 with `beat_tick`, no `done`, `playing` stays 1; clear `loop` during the second pass → ends after that pass with `done`.
3. Pause at `cnt` = 4 of beat 1, hold 25 cycles, resume → beat 1 ends 6 PLAY cycles after resume; `beatnum` frozen and `mute` = 1 while paused.
4. `play_edge` in the same cycle as the tick of beat 3, `loop` = 0 → `beatnum` = 0, `done` pulses, state IDLE (not PAUSE).
5. Drive `rst` low mid-beat 2 asynchronously → all outputs at reset values immediately, before the next clock edge; the next `play` edge restarts from beat 0.
6. With `MELODY_SEQ_GAP_EN` → in each beat `mute` is high for `cnt` 8–9 only; without the macro, `mute` is 0 throughout PLAY.

Source files
------------

// File: rtl/melody_beat_seq_if.sv
// melody_beat_seq_if: play/loop controls in, beat index and playback status out
//   play      raw play/pause button level (asynchronous)
//   loop      repeat the melody when its final beat ends
//   beatnum   current beat index for the note ROM
//   beat_tick one-cycle pulse on each beat advance or wrap
//   playing   high while playing
//   mute      silence request to the tone generator
//   done      one-cycle pulse when a non-looped melody ends
interface melody_beat_seq_if;
  logic       play;
  logic       loop;
  logic [7:0] beatnum;
  logic       beat_tick;
  logic       playing;
  logic       mute;
  logic       done;
  modport master (output play, loop, input beatnum, beat_tick, playing, mute, done);
  modport slave  (input play, loop, output beatnum, beat_tick, playing, mute, done);
endinterface

// File: rtl/melody_beat_seq.sv
// melody_beat_seq: beat divider with play/pause/loop FSM feeding the note ROM
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  slave side of melody_beat_seq_if (play, loop in; beatnum, beat_tick, playing, mute, done out)
//   MELODY_SEQ_GAP_EN: when defined, mute also covers the last GAP_CYC cycles of every beat
module melody_beat_seq #(
  parameter int         CLK_HZ    = 100_000_000,
  parameter int         BEAT_HZ   = 8,
  parameter logic [7:0] LAST_BEAT = 8'd127,
  parameter int         GAP_CYC   = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  melody_beat_seq_if.slave bus
);
  localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;
  localparam int CW = $clog2(BEAT_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(BEAT_DIV - 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  if (BEAT_DIV < 2 || GAP_CYC >= BEAT_DIV) begin : g_bad_cfg
    $error("melody_beat_seq: need BEAT_DIV >= 2 and GAP_CYC < BEAT_DIV");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    beatnum_q, beatnum_d;
  logic          beat_tick_q, beat_tick_d;
  logic          playing_q, playing_d;
  logic          done_q, done_d;
  logic          s1_q, s1_d, s2_q, s2_d, d_q, d_d;
  logic          play_edge, tick;

  assign play_edge = s2_q & ~d_q;
  assign tick = (state_q == S_PLAY) && (cnt_q == CNT_MAX);

  always_comb begin
    s1_d = bus.play;
    s2_d = s1_q;
    d_d = s2_q;
    state_d = state_q;
    cnt_d = cnt_q;
    beatnum_d = beatnum_q;
    beat_tick_d = 1'b0;
    done_d = 1'b0;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      beatnum_d = '0;
      state_d = play_edge ? S_PLAY : S_IDLE;
    end else if (state_q == S_PAUSE) begin
      state_d = play_edge ? S_PLAY : S_PAUSE;
    end else if (state_q == S_PLAY) begin
      // a tick coinciding with a play edge still advances; the edge then pauses,
      // unless the melody ends here, in which case IDLE wins and the edge is consumed
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      state_d = play_edge ? S_PAUSE : S_PLAY;
      if (tick) begin
        beat_tick_d = 1'b1;
        beatnum_d = (beatnum_q == LAST_BEAT) ? 8'd0 : beatnum_q + 8'd1;
        if (beatnum_q == LAST_BEAT && !bus.loop) begin
          state_d = S_IDLE;
          done_d = 1'b1;
        end
      end
    end else begin
      state_d = S_IDLE;
      cnt_d = '0;
      beatnum_d = '0;
    end
    playing_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      beatnum_q <= '0;
      beat_tick_q <= 1'b0;
      playing_q <= 1'b0;
      done_q <= 1'b0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      beatnum_q <= beatnum_d;
      beat_tick_q <= beat_tick_d;
      playing_q <= playing_d;
      done_q <= done_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      d_q <= d_d;
    end
  end

  assign bus.beatnum = beatnum_q;
  assign bus.beat_tick = beat_tick_q;
  assign bus.playing = playing_q;
  assign bus.done = done_q;
`ifdef MELODY_SEQ_GAP_EN
  localparam logic [CW-1:0] GAP_TH = CW'(BEAT_DIV - GAP_CYC);
  assign bus.mute = ~playing_q | (cnt_q >= GAP_TH);
`else
  assign bus.mute = ~playing_q;
`endif
endmodule
